// File: rtl/alu_multi_channel_if.sv
// Command/result bundle between the dispatcher, the multi-channel ALU and the collector.
// Channel n occupies bit n of the scalar vectors and slice n of the packed vectors.
interface alu_multi_channel_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32
);
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [3*NUM_CH-1:0]      in_cmd;
  logic [DATA_W*NUM_CH-1:0] in_data1;
  logic [DATA_W*NUM_CH-1:0] in_data2;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [2*NUM_CH-1:0]      out_resp;
  logic [DATA_W*NUM_CH-1:0] out_data;
  logic [NUM_CH-1:0]        ch_busy;

  modport master (
    output in_valid, in_cmd, in_data1, in_data2, out_ready,
    input  in_ready, out_valid, out_resp, out_data, ch_busy
  );

  modport slave (
    input  in_valid, in_cmd, in_data1, in_data2, out_ready,
    output in_ready, out_valid, out_resp, out_data, ch_busy
  );
endinterface

// File: rtl/alu_multi_channel.sv
// NUM_CH independent ALU channels, each an IDLE -> BUSY -> DONE handshake FSM with a
// fixed per-opcode latency and a held result under output backpressure.
module alu_multi_channel #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 32,
  parameter int ALU_LAT = 2,
  parameter int MUL_LAT = 4
) (
  input  logic               clock,
  input  logic               reset,
  alu_multi_channel_if.slave bus
);

  localparam int MAX_LAT = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_OVF  = 2'd2;
  localparam logic [1:0] RESP_ERR  = 2'd3;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  logic [NUM_CH-1:0]        ready_vec;
  logic [NUM_CH-1:0]        valid_vec;
  logic [NUM_CH-1:0]        busy_vec;
  logic [2*NUM_CH-1:0]      resp_vec;
  logic [DATA_W*NUM_CH-1:0] data_vec;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] a_q, b_q, res_q, res_d;
    logic [1:0]        resp_q, resp_d;
    logic [CNT_W-1:0]  cnt_q, lat_sel;
    logic [2:0]        cmd;
    logic              accept;
    logic [DATA_W:0]   add_full;
    logic [2*DATA_W-1:0] mul_full;

    assign cmd    = bus.in_cmd[3*n +: 3];
    assign accept = bus.in_valid[n] && (state_q == IDLE);

    // Reserved opcode 7 still takes a one-cycle trip through BUSY to report ERROR.
    always_comb begin
      lat_sel = CNT_W'(ALU_LAT);
      if (cmd == OP_MUL)
        lat_sel = CNT_W'(MUL_LAT);
      else if (cmd == 3'd7)
        lat_sel = CNT_W'(1);
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE:    if (accept && (cmd != OP_NOP)) state_d = BUSY;
        BUSY:    if (cnt_q == CNT_W'(1)) state_d = DONE;
        DONE:    if (bus.out_ready[n]) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    assign add_full = {1'b0, a_q} + {1'b0, b_q};
    assign mul_full = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};

    always_comb begin
      res_d  = '0;
      resp_d = RESP_ERR;
      case (op_q)
        OP_ADD: begin
          res_d  = add_full[DATA_W-1:0];
          resp_d = add_full[DATA_W] ? RESP_OVF : RESP_OK;
        end
        OP_SUB: begin
          res_d  = a_q - b_q;
          resp_d = (a_q < b_q) ? RESP_OVF : RESP_OK;
        end
        OP_MUL: begin
          res_d  = mul_full[DATA_W-1:0];
          resp_d = (|mul_full[2*DATA_W-1:DATA_W]) ? RESP_OVF : RESP_OK;
        end
        OP_AND: begin res_d = a_q & b_q; resp_d = RESP_OK; end
        OP_OR:  begin res_d = a_q | b_q; resp_d = RESP_OK; end
        OP_XOR: begin res_d = a_q ^ b_q; resp_d = RESP_OK; end
        default: begin res_d = '0; resp_d = RESP_ERR; end
      endcase
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        op_q    <= OP_NOP;
        a_q     <= '0;
        b_q     <= '0;
        cnt_q   <= '0;
        res_q   <= '0;
        resp_q  <= RESP_NONE;
      end else begin
        state_q <= state_d;
        if (accept) begin
          op_q  <= cmd;
          a_q   <= bus.in_data1[DATA_W*n +: DATA_W];
          b_q   <= bus.in_data2[DATA_W*n +: DATA_W];
          cnt_q <= lat_sel;
        end else if (state_q == BUSY) begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
        if ((state_q == BUSY) && (cnt_q == CNT_W'(1))) begin
          res_q  <= res_d;
          resp_q <= resp_d;
        end
      end
    end

    // Result registers are masked so the collector sees zeros whenever nothing is offered.
    assign ready_vec[n]                 = (state_q == IDLE);
    assign busy_vec[n]                  = (state_q != IDLE);
    assign valid_vec[n]                 = (state_q == DONE);
    assign resp_vec[2*n +: 2]           = (state_q == DONE) ? resp_q : RESP_NONE;
    assign data_vec[DATA_W*n +: DATA_W] = (state_q == DONE) ? res_q : '0;
  end

  assign bus.in_ready  = ready_vec;
  assign bus.ch_busy   = busy_vec;
  assign bus.out_valid = valid_vec;
  assign bus.out_resp  = resp_vec;
  assign bus.out_data  = data_vec;

endmodule

// File: tb/tb_alu_multi_channel.sv
// Directed-vector bench for alu_multi_channel: hand-computed results, latencies,
// backpressure hold, reserved opcode, NOP discard and reset abandonment.
module tb_alu_multi_channel;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 32;
  localparam int ALU_LAT = 2;
  localparam int MUL_LAT = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   num_checks = 0;
  int   num_errors = 0;

  alu_multi_channel_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  alu_multi_channel #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one command at a negedge, lets the next posedge accept it, then withdraws it.
  task automatic applyStimulus(input int ch, input logic [2:0] cmd,
                               input logic [31:0] a, input logic [31:0] b);
    bus.in_valid[ch]           = 1'b1;
    bus.in_cmd[3*ch +: 3]      = cmd;
    bus.in_data1[32*ch +: 32]  = a;
    bus.in_data2[32*ch +: 32]  = b;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid[ch] = 1'b0;
  endtask

  task automatic runOp(input string tag, input int ch, input logic [2:0] cmd,
                       input logic [31:0] a, input logic [31:0] b, input int lat,
                       input logic [1:0] exp_resp, input logic [31:0] exp_data);
    int cycles = 0;
    int busy_cnt = 0;
    applyStimulus(ch, cmd, a, b);
    checkOutput({tag, "_ready_low"}, 64'(bus.in_ready[ch]), 64'd0);
    while (!bus.out_valid[ch] && cycles < 20) begin
      if (bus.ch_busy[ch]) busy_cnt++;
      @(negedge clock);
      cycles++;
    end
    if (bus.ch_busy[ch]) busy_cnt++;
    checkOutput({tag, "_lat"}, 64'(cycles), 64'(lat));
    checkOutput({tag, "_resp"}, 64'(bus.out_resp[2*ch +: 2]), 64'(exp_resp));
    checkOutput({tag, "_data"}, 64'(bus.out_data[32*ch +: 32]), 64'(exp_data));
    checkOutput({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(lat + 1));
    @(negedge clock);
    checkOutput({tag, "_valid_after"}, 64'(bus.out_valid[ch]), 64'd0);
    checkOutput({tag, "_ready_after"}, 64'(bus.in_ready[ch]), 64'd1);
    checkOutput({tag, "_resp_after"}, 64'(bus.out_resp[2*ch +: 2]), 64'd0);
  endtask

  initial begin
    int cycles;
    bus.in_valid  = '0;
    bus.in_cmd    = '0;
    bus.in_data1  = '0;
    bus.in_data2  = '0;
    bus.out_ready = '1;

    repeat (3) @(negedge clock);
    checkOutput("rst_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_busy",  64'(bus.ch_busy),   64'd0);
    checkOutput("rst_resp",  64'(bus.out_resp),  64'd0);
    checkOutput("rst_data",  64'(bus.out_data[63:0]), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_ready", 64'(bus.in_ready), 64'hF);

    runOp("add_ovf", 0, 3'd1, 32'hFFFF_FFFF, 32'd1, ALU_LAT, 2'd2, 32'd0);
    runOp("add_ok",  0, 3'd1, 32'd100, 32'd23, ALU_LAT, 2'd1, 32'd123);
    runOp("mul_ovf", 1, 3'd2, 32'h0001_0000, 32'h0001_0000, MUL_LAT, 2'd2, 32'd0);
    runOp("mul_ok",  1, 3'd2, 32'd3, 32'd5, MUL_LAT, 2'd1, 32'd15);
    runOp("sub_ovf", 2, 3'd4, 32'd5, 32'd7, ALU_LAT, 2'd2, 32'hFFFF_FFFE);
    runOp("sub_ok",  2, 3'd4, 32'd7, 32'd5, ALU_LAT, 2'd1, 32'd2);
    runOp("xor",     3, 3'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, ALU_LAT, 2'd1, 32'h0FF0_0FF0);
    runOp("or",      3, 3'd5, 32'hF0F0_0000, 32'h0000_0F0F, ALU_LAT, 2'd1, 32'hF0F0_0F0F);
    runOp("op7",     1, 3'd7, 32'd9, 32'd4, 1, 2'd3, 32'd0);

    // Backpressure: result must sit unchanged while a new command is offered and ignored.
    bus.out_ready[0] = 1'b0;
    applyStimulus(0, 3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00);
    cycles = 0;
    while (!bus.out_valid[0] && cycles < 20) begin
      @(negedge clock);
      cycles++;
    end
    checkOutput("and_lat", 64'(cycles), 64'(ALU_LAT));
    bus.in_valid[0]      = 1'b1;
    bus.in_cmd[2:0]      = 3'd1;
    bus.in_data1[31:0]   = 32'd1;
    bus.in_data2[31:0]   = 32'd1;
    for (int i = 0; i < 10; i++) begin
      checkOutput("hold_valid", 64'(bus.out_valid[0]), 64'd1);
      checkOutput("hold_data",  64'(bus.out_data[31:0]), 64'hF000_F000);
      checkOutput("hold_resp",  64'(bus.out_resp[1:0]), 64'd1);
      checkOutput("hold_ready", 64'(bus.in_ready[0]), 64'd0);
      @(negedge clock);
    end
    bus.in_valid[0]  = 1'b0;
    bus.out_ready[0] = 1'b1;
    @(negedge clock);
    checkOutput("release_ready", 64'(bus.in_ready[0]), 64'd1);
    checkOutput("release_valid", 64'(bus.out_valid[0]), 64'd0);

    applyStimulus(2, 3'd0, 32'd11, 32'd22);
    for (int i = 0; i < 5; i++) begin
      checkOutput("nop_valid", 64'(bus.out_valid[2]), 64'd0);
      checkOutput("nop_ready", 64'(bus.in_ready[2]), 64'd1);
      @(negedge clock);
    end

    // All channels accept together, then reset one cycle later throws the work away.
    bus.in_valid = 4'hF;
    bus.in_cmd   = {3'd6, 3'd4, 3'd2, 3'd1};
    bus.in_data1 = {32'd1, 32'd2, 32'd3, 32'd4};
    bus.in_data2 = {32'd5, 32'd6, 32'd7, 32'd8};
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = '0;
    checkOutput("all_busy", 64'(bus.ch_busy), 64'hF);
    reset = 1'b1;
    #1;
    checkOutput("async_rst_busy", 64'(bus.ch_busy), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checkOutput("post_rst_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("post_rst_ready", 64'(bus.in_ready), 64'hF);
    end
    runOp("add_fresh", 0, 3'd1, 32'd2, 32'd2, ALU_LAT, 2'd1, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_errors);
    $finish;
  end

endmodule
